i2s_tx_sample_fifo: RTL and testbench

Stereo sample buffer upstream of the I2S transmit path. It accepts left/right sample pairs from the DSP pipeline over a valid/ready stream. It presents them to the transmitter's rd_en/rd_valid read port, one pair per frame request. It also absorbs rate jitter between the producer and the I2S frame clock, and flags underflow and overflow conditions.

---
 rtl/i2s_tx_sample_fifo_pkg.sv | 19 +
 rtl/i2s_tx_sample_fifo_if.sv | 25 ++
 rtl/i2s_tx_sample_fifo_mem.sv | 44 ++++
 rtl/i2s_tx_sample_fifo.sv | 106 ++++++++++
 tb/tb_i2s_tx_sample_fifo.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/i2s_tx_sample_fifo_pkg.sv
// Shared types and helpers for the I2S transmit sample FIFO.
// Provides the default sample width, the stereo pair type and the
// level-counter width helper used by the FIFO and its testbench.
package i2s_pkg;

    localparam int I2S_DW = 24;

    // One left/right sample pair as it travels through the FIFO.
    typedef struct packed {
        logic [I2S_DW-1:0] l;
        logic [I2S_DW-1:0] r;
    } stereo_t;

    // Pointer/level width: one extra bit so that full and empty differ.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/i2s_tx_sample_fifo_if.sv
// Stream bundle between the DSP producer, the FIFO and the I2S transmitter.
// master: the producer/transmitter side; slave: the FIFO.
interface i2s_tx_sample_fifo_if #(
    parameter int DW = 24
);
    logic [DW-1:0] s_ldata;
    logic [DW-1:0] s_rdata;
    logic          s_valid;
    logic          s_ready;
    logic          rd_en;
    logic          rd_valid;
    logic [DW-1:0] ldata;
    logic [DW-1:0] rdata;

    modport master (
        output s_ldata, s_rdata, s_valid, rd_en,
        input  s_ready, rd_valid, ldata, rdata
    );

    modport slave (
        input  s_ldata, s_rdata, s_valid, rd_en,
        output s_ready, rd_valid, ldata, rdata
    );

endinterface

// File: rtl/i2s_tx_sample_fifo_mem.sv
// Simple dual-port sample storage: synchronous write, registered read.
// The read register doubles as the FIFO output register, so it resets
// to zero and can be cleared to emit silence on an empty read.
module i2s_fifo_mem #(
    parameter  int W     = 48,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    input  logic          rd_clr,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem [DEPTH];

    // Store an accepted pair.
    // NOTE: the array has no reset so it can map onto RAM primitives;
    // stale contents are never visible because the pointers gate every read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port; holds its value between reads.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_clr) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/i2s_tx_sample_fifo.sv
// Stereo sample FIFO feeding the I2S transmitter.
// Holds the pointers, level, sticky flags and read-valid register; storage
// and the data output register live in i2s_fifo_mem.
// Optional feature: define I2S_FIFO_UNDERFLOW_MUTE_EN to answer a read of an
// empty FIFO with rd_valid=1 and zero samples instead of no response.
module i2s_tx_sample_fifo
    import i2s_pkg::*;
#(
    parameter  int DW    = I2S_DW,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = level_width(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    i2s_tx_sample_fifo_if.slave  bus,
    output logic [LW-1:0]        level,
    output logic                 underflow,
    output logic                 overflow,
    input  logic                 clr_flags
);

    logic [LW-1:0]   wr_ptr;
    logic [LW-1:0]   rd_ptr;
    logic            full;
    logic            empty;
    logic            wr_fire;
    logic            rd_fire;
    logic            rd_empty;
    logic            rd_clr;
    logic            rd_valid_q;
    logic [2*DW-1:0] rd_word;

    // Extra pointer MSB distinguishes full (MSBs differ) from empty (equal).
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign level = wr_ptr - rd_ptr;

    assign bus.s_ready = !full;
    assign wr_fire     = bus.s_valid && !full;
    // Empty is judged on registered state, so a same-cycle write never
    // falls through to a read.
    assign rd_fire     = bus.rd_en && !empty;
    assign rd_empty    = bus.rd_en && empty;

`ifdef I2S_FIFO_UNDERFLOW_MUTE_EN
    assign rd_clr = rd_empty;
`else
    assign rd_clr = 1'b0;
`endif

    // Advance pointers on accepted writes and reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
            if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Read-valid pulse one cycle after each serviced request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
        end else begin
`ifdef I2S_FIFO_UNDERFLOW_MUTE_EN
            rd_valid_q <= bus.rd_en;
`else
            rd_valid_q <= rd_fire;
`endif
        end
    end

    // Sticky error flags; a new event in the clearing cycle wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underflow <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            underflow <= rd_empty || (underflow && !clr_flags);
            overflow  <= (bus.s_valid && full) || (overflow && !clr_flags);
        end
    end

    i2s_fifo_mem #(
        .W     (2*DW),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_fire),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data ({bus.s_ldata, bus.s_rdata}),
        .rd_en   (rd_fire),
        .rd_clr  (rd_clr),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (rd_word)
    );

    assign bus.rd_valid = rd_valid_q;
    assign bus.ldata    = rd_word[2*DW-1:DW];
    assign bus.rdata    = rd_word[DW-1:0];

endmodule

// File: tb/tb_i2s_tx_sample_fifo.sv
// Testbench for i2s_tx_sample_fifo: directed vector table plus hand-written
// sequences for fill/overflow, pointer wrap and mid-stream reset.
// Expected values follow I2S_FIFO_UNDERFLOW_MUTE_EN when it is defined.
module tb_i2s_tx_sample_fifo;
    import i2s_pkg::*;

    localparam int DW    = 24;
    localparam int DEPTH = 16;
    localparam int LW    = level_width(DEPTH);
`ifdef I2S_FIFO_UNDERFLOW_MUTE_EN
    localparam bit MUTE = 1'b1;
`else
    localparam bit MUTE = 1'b0;
`endif

    typedef struct {
        logic          s_valid;
        stereo_t       din;
        logic          rd_en;
        logic          clr;
        logic          exp_valid;
        stereo_t       exp_out;
        logic [LW-1:0] exp_level;
        logic          exp_uf;
    } vec_t;

    logic          clk;
    logic          rst_n;
    logic          clr_flags;
    logic [LW-1:0] level;
    logic          underflow;
    logic          overflow;

    int tests = 0;
    int fails = 0;

    i2s_tx_sample_fifo_if #(.DW(DW)) bus ();

    i2s_tx_sample_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .level     (level),
        .underflow (underflow),
        .overflow  (overflow),
        .clr_flags (clr_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic sv, input logic [DW-1:0] l, input logic [DW-1:0] r,
                         input logic rd, input logic clr);
        bus.s_valid = sv;
        bus.s_ldata = l;
        bus.s_rdata = r;
        bus.rd_en   = rd;
        clr_flags   = clr;
    endtask

    function automatic vec_t mk(input logic sv, input logic [DW-1:0] l, input logic [DW-1:0] r,
                                input logic rd, input logic clr, input logic ev,
                                input logic [DW-1:0] el, input logic [DW-1:0] er,
                                input logic [LW-1:0] elvl, input logic euf);
        vec_t v;
        v.s_valid   = sv;
        v.din.l     = l;
        v.din.r     = r;
        v.rd_en     = rd;
        v.clr       = clr;
        v.exp_valid = ev;
        v.exp_out.l = el;
        v.exp_out.r = er;
        v.exp_level = elvl;
        v.exp_uf    = euf;
        return v;
    endfunction

    vec_t            vecs[$];
    logic [DW-1:0]   model_q[$];

    initial begin
        logic [DW-1:0] hl;
        logic [DW-1:0] hr;
        logic [DW-1:0] exp_l;

        // Data held after an empty read: zero when muted, else last real pair.
        hl = MUTE ? 24'h0 : 24'h000003;
        hr = MUTE ? 24'h0 : 24'h800003;

        vecs.push_back(mk(1, 24'h000001, 24'h800001, 0, 0, 0,    24'h0,      24'h0,      1, 0));
        vecs.push_back(mk(1, 24'h000002, 24'h800002, 0, 0, 0,    24'h0,      24'h0,      2, 0));
        vecs.push_back(mk(1, 24'h000003, 24'h800003, 0, 0, 0,    24'h0,      24'h0,      3, 0));
        vecs.push_back(mk(0, 24'h0,      24'h0,      1, 0, 1,    24'h000001, 24'h800001, 2, 0));
        vecs.push_back(mk(0, 24'h0,      24'h0,      1, 0, 1,    24'h000002, 24'h800002, 1, 0));
        vecs.push_back(mk(0, 24'h0,      24'h0,      1, 0, 1,    24'h000003, 24'h800003, 0, 0));
        vecs.push_back(mk(0, 24'h0,      24'h0,      0, 0, 0,    24'h000003, 24'h800003, 0, 0));
        vecs.push_back(mk(0, 24'h0,      24'h0,      1, 0, MUTE, hl,         hr,         0, 1));
        vecs.push_back(mk(0, 24'h0,      24'h0,      0, 0, 0,    hl,         hr,         0, 1));
        vecs.push_back(mk(0, 24'h0,      24'h0,      0, 1, 0,    hl,         hr,         0, 0));
        vecs.push_back(mk(0, 24'h0,      24'h0,      1, 1, MUTE, hl,         hr,         0, 1));
        vecs.push_back(mk(0, 24'h0,      24'h0,      0, 1, 0,    hl,         hr,         0, 0));
        vecs.push_back(mk(1, 24'h00000A, 24'h00000B, 1, 0, MUTE, hl,         hr,         1, 1));
        vecs.push_back(mk(0, 24'h0,      24'h0,      1, 1, 1,    24'h00000A, 24'h00000B, 0, 0));
        vecs.push_back(mk(0, 24'h0,      24'h0,      0, 0, 0,    24'h00000A, 24'h00000B, 0, 0));

        // Reset state, observed while reset is still asserted.
        rst_n = 1'b0;
        drive(0, '0, '0, 0, 0);
        #1;
        check("reset_level",    level,        0);
        check("reset_s_ready",  bus.s_ready,  1);
        check("reset_rd_valid", bus.rd_valid, 0);
        check("reset_ldata",    bus.ldata,    0);
        check("reset_rdata",    bus.rdata,    0);
        check("reset_flags",    {underflow, overflow}, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Vector table: inputs applied for one edge, outputs checked after it.
        foreach (vecs[i]) begin
            drive(vecs[i].s_valid, vecs[i].din.l, vecs[i].din.r, vecs[i].rd_en, vecs[i].clr);
            tick();
            check($sformatf("v%0d_rd_valid", i),  bus.rd_valid, vecs[i].exp_valid);
            check($sformatf("v%0d_ldata", i),     bus.ldata,    vecs[i].exp_out.l);
            check($sformatf("v%0d_rdata", i),     bus.rdata,    vecs[i].exp_out.r);
            check($sformatf("v%0d_level", i),     level,        vecs[i].exp_level);
            check($sformatf("v%0d_underflow", i), underflow,    vecs[i].exp_uf);
            check($sformatf("v%0d_overflow", i),  overflow,     0);
        end

        // Fill to DEPTH with s_valid held, then push once more.
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 24'h000100 + 24'(i), 24'h900100 + 24'(i), 0, 0);
            tick();
        end
        check("full_level",    level,       DEPTH);
        check("full_s_ready",  bus.s_ready, 0);
        check("full_overflow", overflow,    0);
        drive(1, 24'h000110, 24'h900110, 0, 0);
        tick();
        check("ovf_flag",  overflow, 1);
        check("ovf_level", level,    DEPTH);
        drive(0, '0, '0, 1, 0);
        tick();
        check("ovf_read_valid",   bus.rd_valid, 1);
        check("ovf_read_ldata",   bus.ldata,    24'h000100);
        check("ovf_read_level",   level,        DEPTH - 1);
        check("ovf_read_s_ready", bus.s_ready,  1);
        for (int i = 1; i < DEPTH; i++) begin
            tick();
            check($sformatf("drain%0d_ldata", i), bus.ldata, 24'h000100 + 24'(i));
            check($sformatf("drain%0d_rdata", i), bus.rdata, 24'h900100 + 24'(i));
        end
        drive(0, '0, '0, 0, 1);
        tick();
        check("ovf_cleared", overflow, 0);
        check("drain_level", level,    0);
        drive(0, '0, '0, 0, 0);

        // Level 5 with simultaneous write/read for 40 cycles across the wrap.
        for (int i = 0; i < 5; i++) begin
            drive(1, 24'h000200 + 24'(i), 24'h000200 + 24'(i), 0, 0);
            model_q.push_back(24'h000200 + 24'(i));
            tick();
        end
        check("wrap_start_level", level, 5);
        for (int k = 0; k < 40; k++) begin
            exp_l = model_q.pop_front();
            drive(1, 24'h000205 + 24'(k), 24'h000205 + 24'(k), 1, 0);
            model_q.push_back(24'h000205 + 24'(k));
            tick();
            check($sformatf("wrap%0d_valid", k), bus.rd_valid, 1);
            check($sformatf("wrap%0d_ldata", k), bus.ldata,    exp_l);
            check($sformatf("wrap%0d_rdata", k), bus.rdata,    exp_l);
            check($sformatf("wrap%0d_level", k), level,        5);
        end
        drive(0, '0, '0, 0, 0);
        tick();

        // Mid-stream reset: start clean, set underflow, build level 7 with a live read.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        drive(0, '0, '0, 1, 0);
        tick();
        for (int i = 0; i < 8; i++) begin
            drive(1, 24'h000300 + 24'(i), 24'h000300 + 24'(i), 0, 0);
            tick();
        end
        drive(0, '0, '0, 1, 0);
        tick();
        check("pre_rst_level",     level,        7);
        check("pre_rst_rd_valid",  bus.rd_valid, 1);
        check("pre_rst_ldata",     bus.ldata,    24'h000300);
        check("pre_rst_underflow", underflow,    1);
        drive(0, '0, '0, 0, 0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_level",    level,        0);
        check("mid_rst_rd_valid", bus.rd_valid, 0);
        check("mid_rst_ldata",    bus.ldata,    0);
        check("mid_rst_flags",    {underflow, overflow}, 0);
        check("mid_rst_s_ready",  bus.s_ready,  1);
        tick();
        rst_n = 1'b1;
        drive(1, 24'h000400, 24'h000401, 0, 0);
        tick();
        check("post_rst_level", level, 1);
        drive(0, '0, '0, 1, 0);
        tick();
        check("post_rst_valid", bus.rd_valid, 1);
        check("post_rst_ldata", bus.ldata,    24'h000400);
        check("post_rst_rdata", bus.rdata,    24'h000401);
        check("post_rst_empty", level,        0);
        drive(0, '0, '0, 0, 0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
